// File: rtl/floating_point_arith_unit.sv
// Single-precision add / multiply / integer power / pass-through unit.
// Add, multiply and pass-through finish one cycle after acceptance; power iterates the multiplier.
module floating_point_arith_unit #(
  parameter int MAX_POW = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  n,
  output logic [31:0] res,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0]  OP_ADD  = 2'b00;
  localparam logic [1:0]  OP_MUL  = 2'b01;
  localparam logic [1:0]  OP_POW  = 2'b10;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [2:0]  MAX_N   = 3'(MAX_POW);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_PWR} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] res_q, res_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_clamped;

  // ---------------- multiply datapath (shared by multiply and power) ----------------
  logic [31:0]       mul_x, mul_y, mul_res;
  logic [47:0]       prod;
  logic [24:0]       prod_top;
  logic signed [9:0] mexp;
  logic [22:0]       mfrac;
  logic              msign;

  always_comb begin
    mul_x    = (state_q == S_PWR) ? acc_q : a_q;
    mul_y    = (state_q == S_PWR) ? a_q   : b_q;
    msign    = mul_x[31] ^ mul_y[31];
    prod     = 48'({1'b1, mul_x[22:0]}) * 48'({1'b1, mul_y[22:0]});
    prod_top = 25'(prod >> 23);
    mexp     = $signed({2'b00, mul_x[30:23]}) + $signed({2'b00, mul_y[30:23]}) - 10'sd127;
    if (prod_top[24]) begin
      mfrac = prod_top[23:1];
      mexp  = mexp + 10'sd1;
    end else begin
      mfrac = prod_top[22:0];
    end
    if (mul_x[30:23] == 8'hFF || mul_y[30:23] == 8'hFF) begin
      mul_res = QNAN;
    end else if (mul_x[30:23] == 8'h00 || mul_y[30:23] == 8'h00) begin
      mul_res = {msign, 31'b0};
    end else if (mexp <= 10'sd0) begin
      mul_res = {msign, 31'b0};
    end else if (mexp >= 10'sd255) begin
      mul_res = {msign, 8'hFF, 23'b0};
    end else begin
      mul_res = {msign, mexp[7:0], mfrac};
    end
  end

  // ---------------- add datapath ----------------
  logic [7:0]        ea, eb, el, es, shamt;
  logic [23:0]       ma, mb, ml, ms, ms_al;
  logic              sl, ss;
  logic [24:0]       sum;
  logic [4:0]        lz;
  logic [22:0]       norm, afrac;
  logic signed [9:0] aexp;
  logic [31:0]       add_res;

  always_comb begin
    ea = a_q[30:23];
    eb = b_q[30:23];
    ma = (ea == 8'h00) ? 24'h0 : {1'b1, a_q[22:0]};
    mb = (eb == 8'h00) ? 24'h0 : {1'b1, b_q[22:0]};
    if ({ea, ma} >= {eb, mb}) begin
      el = ea; ml = ma; sl = a_q[31];
      es = eb; ms = mb; ss = b_q[31];
    end else begin
      el = eb; ml = mb; sl = b_q[31];
      es = ea; ms = ma; ss = a_q[31];
    end
    shamt = el - es;
    ms_al = ms >> shamt;
    sum   = (sl == ss) ? ({1'b0, ml} + {1'b0, ms_al}) : ({1'b0, ml} - {1'b0, ms_al});
    lz    = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (sum[i]) lz = 5'(23 - i);
    end
    norm = 23'(sum[23:0] << lz);
    aexp = $signed({2'b00, el});
    if (sum[24]) begin
      afrac = sum[23:1];
      aexp  = aexp + 10'sd1;
    end else begin
      afrac = norm;
      aexp  = aexp - $signed({5'b00000, lz});
    end
    if (ea == 8'hFF || eb == 8'hFF) begin
      add_res = QNAN;
    end else if (sum == 25'd0) begin
      add_res = 32'h0000_0000;
    end else if (aexp <= 10'sd0) begin
      add_res = {sl, 31'b0};
    end else if (aexp >= 10'sd255) begin
      add_res = {sl, 8'hFF, 23'b0};
    end else begin
      add_res = {sl, aexp[7:0], afrac};
    end
  end

  // ---------------- control ----------------
  always_comb begin
    n_clamped = (n > MAX_N) ? MAX_N : n;
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    res_d     = res_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    n_d       = n_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_PEND: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        case (op_q)
          OP_ADD:  res_d = add_res;
          OP_MUL:  res_d = mul_res;
          OP_POW:  res_d = (n_q == 3'd0) ? FP_ONE : a_q;
          default: res_d = a_q;
        endcase
      end
      S_PWR: begin
        acc_d = mul_res;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          res_d   = mul_res;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // A new request may overlap the completion cycle of a single-cycle op.
    if (start && !busy_q) begin
      a_d  = a;
      b_d  = b;
      op_d = op;
      n_d  = n_clamped;
      if (op == OP_POW && n_clamped >= 3'd2) begin
        state_d = S_PWR;
        busy_d  = 1'b1;
        acc_d   = a;
        cnt_d   = n_clamped - 3'd1;
      end else begin
        state_d = S_PEND;
        busy_d  = (op == OP_POW);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 32'h0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      acc_q   <= 32'h0;
      op_q    <= 2'b00;
      n_q     <= 3'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res  = res_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_floating_point_arith_unit.sv
// Directed and randomised checks of floating_point_arith_unit against a value-level reference model.
module tb_floating_point_arith_unit;

  localparam int MAX_POW = 5;
  localparam logic [1:0] OP_ADD = 2'b00, OP_MUL = 2'b01, OP_POW = 2'b10, OP_PASS = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic [2:0]  n = 3'd0;
  logic [31:0] res;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  floating_point_arith_unit #(.MAX_POW(MAX_POW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .n(n),
    .res(res), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (value level) ----------------
  function automatic logic [31:0] pack(input logic s, input int e, input longint frac_full);
    if (e <= 0) return {s, 31'b0};
    if (e >= 255) return {s, 8'hFF, 23'b0};
    return {s, 8'(e), 23'(frac_full)};
  endfunction

  function automatic logic [31:0] model_mul(input logic [31:0] x, input logic [31:0] y);
    int ex = int'(x[30:23]);
    int ey = int'(y[30:23]);
    logic s = x[31] ^ y[31];
    longint p;
    int e;
    if (ex == 255 || ey == 255) return 32'h7FC0_0000;
    if (ex == 0 || ey == 0) return {s, 31'b0};
    p = (longint'(x[22:0]) + (64'sd1 << 23)) * (longint'(y[22:0]) + (64'sd1 << 23));
    e = ex + ey - 127;
    while (p >= (64'sd1 << 47)) begin p = p >> 1; e++; end
    return pack(s, e, p >> 23);
  endfunction

  function automatic logic [31:0] model_add(input logic [31:0] x, input logic [31:0] y);
    int ex = int'(x[30:23]);
    int ey = int'(y[30:23]);
    longint mx = (ex == 0) ? 0 : longint'(x[22:0]) + (64'sd1 << 23);
    longint my = (ey == 0) ? 0 : longint'(y[22:0]) + (64'sd1 << 23);
    longint ml, ms, s;
    int el, es, e, d;
    logic sl, ss;
    if (ex == 255 || ey == 255) return 32'h7FC0_0000;
    if (longint'(ex) * (64'sd1 << 24) + mx >= longint'(ey) * (64'sd1 << 24) + my) begin
      el = ex; ml = mx; sl = x[31]; es = ey; ms = my; ss = y[31];
    end else begin
      el = ey; ml = my; sl = y[31]; es = ex; ms = mx; ss = x[31];
    end
    d = el - es;
    ms = (d >= 24) ? 0 : (ms >> d);
    s = (sl == ss) ? ml + ms : ml - ms;
    if (s == 0) return 32'h0;
    e = el;
    while (s >= (64'sd1 << 24)) begin s = s >> 1; e++; end
    while (s < (64'sd1 << 23)) begin s = s << 1; e--; end
    return pack(sl, e, s);
  endfunction

  function automatic int clamp_n(input logic [2:0] nn);
    return (int'(nn) > MAX_POW) ? MAX_POW : int'(nn);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [2:0] nn);
    logic [31:0] r;
    int k;
    case (o)
      OP_ADD: return model_add(x, y);
      OP_MUL: return model_mul(x, y);
      OP_POW: begin
        k = clamp_n(nn);
        if (k == 0) return 32'h3F80_0000;
        r = x;
        for (int i = 1; i < k; i++) r = model_mul(r, x);
        return r;
      end
      default: return x;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [2:0] nn);
    if (o != OP_POW) return 1;
    return (clamp_n(nn) - 1 > 1) ? clamp_n(nn) - 1 : 1;
  endfunction

  function automatic logic [31:0] rand_fp();
    int sel = $urandom_range(0, 9);
    logic [7:0] e;
    logic [22:0] f = 23'($urandom);
    if ($urandom_range(0, 3) == 0) f = 23'(f & 23'h700000);
    case (sel)
      0: e = 8'h00;
      1: e = 8'hFF;
      2: e = 8'($urandom_range(250, 254));
      3: e = 8'($urandom_range(1, 5));
      default: e = 8'($urandom_range(120, 135));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // ---------------- one transaction ----------------
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] nn, input string tag);
    logic [31:0] exp_res = model(o, x, y, nn);
    int exp_lat = model_lat(o, nn);
    int lat = 0;
    int busy_cycles = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; n = nn;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; n = 3'($urandom);
    if (busy) busy_cycles++;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!done && busy) busy_cycles++;
    end
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "/res"}, res, exp_res);
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "/busy_cycles"}, 32'(busy_cycles), (o == OP_POW) ? 32'(exp_lat) : 32'd0);
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
    $display("op=%0d a=%h b=%h n=%0d -> res=%h lat=%0d (%s)", o, x, y, nn, res, lat, tag);
  endtask

  initial begin
    logic [1:0] ro;
    logic [31:0] rx, ry;
    int lat;

    // reset state
    #3;
    check("reset/res", res, 32'h0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_op(OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 3'd0, "add_1p1");
    check("add_1p1/value", res, 32'h4000_0000);
    run_op(OP_ADD, 32'h3FC0_0000, 32'hBFC0_0000, 3'd0, "add_cancel");
    check("add_cancel/value", res, 32'h0000_0000);
    run_op(OP_ADD, 32'h4040_0000, 32'hBF80_0000, 3'd0, "add_3m1");
    check("add_3m1/value", res, 32'h4000_0000);
    run_op(OP_MUL, 32'h4040_0000, 32'h3F00_0000, 3'd0, "mul_3x05");
    check("mul_3x05/value", res, 32'h3FC0_0000);
    run_op(OP_MUL, 32'h7F00_0000, 32'h4000_0000, 3'd0, "mul_ovf");
    check("mul_ovf/value", res, 32'h7F80_0000);
    run_op(OP_MUL, 32'h0080_0000, 32'h0080_0000, 3'd0, "mul_unf");
    run_op(OP_ADD, 32'h7F80_0000, 32'h3F80_0000, 3'd0, "add_nan");
    run_op(OP_ADD, 32'h0000_1234, 32'hC000_0000, 3'd0, "add_subnorm");
    run_op(OP_PASS, 32'h7F80_0001, 32'h1234_5678, 3'd0, "pass");
    run_op(OP_POW, 32'h4000_0000, 32'h0, 3'd5, "pow_2_5");
    check("pow_2_5/value", res, 32'h4200_0000);
    run_op(OP_POW, 32'h4000_0000, 32'h0, 3'd0, "pow_n0");
    check("pow_n0/value", res, 32'h3F80_0000);
    run_op(OP_POW, 32'hC040_0000, 32'h0, 3'd1, "pow_n1");
    run_op(OP_POW, 32'hBFC0_0000, 32'h0, 3'd2, "pow_n2");
    run_op(OP_POW, 32'h4000_0000, 32'h0, 3'd7, "pow_clamp");
    check("pow_clamp/value", res, 32'h4200_0000);

    // result holds while idle
    repeat (3) @(posedge clk);
    #1 check("hold/res", res, 32'h4200_0000);

    // start during power busy is ignored
    @(negedge clk);
    start = 1'b1; op = OP_POW; a = 32'h4000_0000; n = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 32'h3F80_0000; b = 32'h3F80_0000;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check("ignore/busy_mid", 32'(busy), 32'd1);
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignore/lat", 32'(lat), 32'd4);
    check("ignore/res", res, 32'h4200_0000);
    repeat (2) begin
      @(posedge clk); #1;
      check("ignore/no_extra_done", 32'(done), 32'd0);
    end
    $display("start during busy ignored: res=%h lat=%0d", res, lat);

    // reset in the middle of a power operation
    @(negedge clk);
    start = 1'b1; op = OP_POW; a = 32'h4040_0000; n = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rstmid/busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid/res", res, 32'h0);
    check("rstmid/busy", 32'(busy), 32'd0);
    check("rstmid/done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("rstmid/res_held", res, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("rstmid/no_done", 32'(done), 32'd0);
    end
    $display("reset mid-power: res=%h busy=%0d", res, busy);
    run_op(OP_MUL, 32'h4000_0000, 32'h4040_0000, 3'd0, "after_reset");

    // randomised operations
    for (int i = 0; i < 80; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = rand_fp();
      ry = (ro == OP_ADD && $urandom_range(0, 4) == 0) ? (rx ^ 32'h8000_0000) : rand_fp();
      run_op(ro, rx, ry, 3'($urandom_range(0, 7)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/floating_point_arith_unit.md
FLOATING_POINT_ARITH_UNIT -- requirements
Module: floating_point_arith_unit

Interface
REQ-001 The block SHALL have one parameter: MAX_POW, default 5, the largest supported exponent for the power operation.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request pulse, sampled on the clk edge.
REQ-005 The block SHALL have port op, input, 2 bits: operation select; 00 add, 01 multiply, 10 power, 11 pass-through.
REQ-006 The block SHALL have port a, input, 32 bits: IEEE-754 single operand A, the base for power.
REQ-007 The block SHALL have port b, input, 32 bits: IEEE-754 single operand B, ignored for power and pass-through.
REQ-008 The block SHALL have port n, input, 3 bits: unsigned power exponent.
REQ-009 The block SHALL have port res, output, 32 bits: registered result.
REQ-010 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking res valid.

Function
REQ-012 On a clk edge with start=1 and busy=0, the block SHALL capture a, b, op and n; with busy=1, start SHALL be ignored and inputs not re-sampled.
REQ-013 Add, multiply and pass-through SHALL complete in 1 cycle: res updated and done=1 on the edge after acceptance; busy SHALL stay 0 for these ops.
REQ-014 Power SHALL compute a^n by repeated multiplication, one multiply per cycle, reusing the multiply datapath of REQ-018 and REQ-019.
REQ-015 Power latency SHALL be max(n-1,1) cycles; busy=1 from the acceptance edge until the edge that asserts done.
REQ-016 For power, n=0 SHALL give 0x3F800000 (1.0), n=1 SHALL give a, and n>MAX_POW SHALL be clamped to MAX_POW.
REQ-017 Add SHALL use sign-magnitude arithmetic:
- align to the larger exponent by right-shifting the smaller 24-bit significand, hidden 1 restored;
- add or subtract magnitudes;
- renormalise by leading-one detection;
- truncate toward zero;
- result sign = sign of the larger magnitude;
- exact cancellation gives +0 (0x00000000).
REQ-018 Multiply SHALL:
- set sign = sign(a) XOR sign(b);
- compute exponent = ea + eb - 127;
- form the 24x24-bit significand product;
- normalise by at most one bit;
- truncate toward zero.
REQ-019 Operands with exponent field 0 (zero or subnormal) SHALL be treated as signed zero; results SHALL never be subnormal.
REQ-020 A biased result exponent <=0 SHALL flush res to signed zero; >=255 SHALL saturate res to signed infinity (0x7F800000 | sign<<31).
REQ-021 Any operand with exponent field 255 SHALL make res 0x7FC00000.
REQ-022 res SHALL hold its last value between operations; done SHALL be 1 for exactly one cycle per accepted request.
REQ-023 Pass-through SHALL return a unchanged.

Reset
REQ-024 While rst_n=0, regardless of clk, res SHALL be 0x00000000 and busy=0, done=0; an in-flight operation SHALL be abandoned with no done pulse.
REQ-025 After rst_n rises, the first clk edge with start=1 SHALL be accepted normally.

Verification
REQ-026 Add: a=0x3F800000, b=0x3F800000, op=00 -> next edge res=0x40000000, done=1 for one cycle, busy=0.
REQ-027 Add cancellation: a=0x3FC00000, b=0xBFC00000 -> res=0x00000000; a=0x40400000, b=0xBF800000 -> res=0x40000000.
REQ-028 Multiply: a=0x40400000 (3.0), b=0x3F000000 (0.5), op=01 -> res=0x3FC00000; a=0x7F000000, b=0x40000000 -> res=0x7F800000.
REQ-029 Power: a=0x40000000, n=5, op=10 -> busy high for 4 cycles, then res=0x42000000 with done; n=0 -> res=0x3F800000 after 1 cycle.
REQ-030 Control: start during power busy -> ignored, result unchanged; rst_n pulsed low mid-power -> res=0, busy=0, no done.
